// File: rtl/pipeline_stall_sequencer.sv
// Pipeline stall/flush sequencer for a 5-stage in-order core.
// Resolves load-use hazards, taken branches/jumps and data-memory waits
// into register write enables, bubble and flush controls.
//
// Optional feature: define STALL_PERF_EN to build the saturating
// stall-cycle and flush performance counters. Without it, both counter
// ports read 16'h0000.
//
// Ports:
//   clk             - clock, rising edge
//   reset           - asynchronous active-low reset
//   load_use_i      - load-use hazard between ID/EX and IF/ID
//   branch_taken_i  - taken beq/bne resolved in ID
//   jump_i          - j/jal/jr in ID
//   mem_req_i       - EX/MEM instruction accesses data memory
//   mem_ready_i     - data memory completes the access this cycle
//   pc_write_o      - PC register enable
//   if_id_write_o   - IF/ID register enable
//   ex_mem_write_o  - EX/MEM register enable
//   id_ex_bubble_o  - zero ID/EX control fields
//   mem_wb_bubble_o - zero MEM/WB control fields
//   if_id_flush_o   - replace IF/ID instruction with NOP
//   mem_timeout_o   - sticky data-memory timeout flag
//   stall_cycles_o  - cycles with PC frozen (perf counter)
//   flush_count_o   - cycles with IF/ID flushed (perf counter)
module pipeline_stall_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_use_i,
  input  logic        branch_taken_i,
  input  logic        jump_i,
  input  logic        mem_req_i,
  input  logic        mem_ready_i,
  output logic        pc_write_o,
  output logic        if_id_write_o,
  output logic        ex_mem_write_o,
  output logic        id_ex_bubble_o,
  output logic        mem_wb_bubble_o,
  output logic        if_id_flush_o,
  output logic        mem_timeout_o,
  output logic [15:0] stall_cycles_o,
  output logic [15:0] flush_count_o
);

  localparam int unsigned WAIT_W = 5;
  localparam int unsigned CNT_W  = 16;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_MEM_WAIT   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              timeout_q, timeout_d;

  logic mem_stall_c;
  logic redirect_c;
  logic freeze_c;
  logic lu_stall_c;
  logic flush_ok_c;

  assign mem_stall_c = mem_req_i & ~mem_ready_i;
  assign redirect_c  = branch_taken_i | jump_i;

  // Next-state and control outputs
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    freeze_c   = 1'b0;
    lu_stall_c = 1'b0;
    flush_ok_c = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        if (mem_stall_c) begin
          freeze_c   = 1'b1;
          wait_cnt_d = '0;
          state_d    = ST_MEM_WAIT;
        end else if (load_use_i) begin
          lu_stall_c = 1'b1;
          state_d    = ST_LOAD_STALL;
        end else begin
          flush_ok_c = 1'b1;
        end
      end
      ST_LOAD_STALL: begin
        // The dependent instruction already waited one cycle; load_use_i is stale here.
        if (mem_stall_c) begin
          freeze_c   = 1'b1;
          wait_cnt_d = '0;
          state_d    = ST_MEM_WAIT;
        end else begin
          flush_ok_c = 1'b1;
          state_d    = ST_RUN;
        end
      end
      ST_MEM_WAIT: begin
        if (!mem_ready_i) begin
          freeze_c   = 1'b1;
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          // Give up on the access: flag it and let the pipeline move on.
          if (wait_cnt_q == WAIT_LAST) begin
            timeout_d = 1'b1;
            state_d   = ST_RUN;
          end
        end else if (load_use_i) begin
          lu_stall_c = 1'b1;
          state_d    = ST_LOAD_STALL;
        end else begin
          flush_ok_c = 1'b1;
          state_d    = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  assign pc_write_o      = ~(freeze_c | lu_stall_c);
  assign if_id_write_o   = ~(freeze_c | lu_stall_c);
  assign ex_mem_write_o  = ~freeze_c;
  assign id_ex_bubble_o  = lu_stall_c;
  assign mem_wb_bubble_o = freeze_c;
  // A redirect coinciding with a load-use stall is re-resolved after the stall.
  assign if_id_flush_o   = flush_ok_c & redirect_c;
  assign mem_timeout_o   = timeout_q;

  // State, wait counter and sticky timeout
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

`ifdef STALL_PERF_EN
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;

  // Saturating performance counters
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (!pc_write_o && (stall_cycles_q != {CNT_W{1'b1}})) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end
    if (if_id_flush_o && (flush_count_q != {CNT_W{1'b1}})) begin
      flush_count_d = flush_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stall_cycles_o = stall_cycles_q;
  assign flush_count_o  = flush_count_q;
`else
  assign stall_cycles_o = CNT_W'(0);
  assign flush_count_o  = CNT_W'(0);
`endif

endmodule

// File: tb/tb_pipeline_stall_sequencer.sv
// Scoreboard bench for pipeline_stall_sequencer: a driver applies directed
// vectors shortly after each rising edge and queues the hand-computed
// expected response; a monitor pops and compares on each falling edge.
module tb_pipeline_stall_sequencer;

  // Output vector: {pc_write, if_id_write, ex_mem_write, id_ex_bubble, mem_wb_bubble, if_id_flush}
  localparam logic [5:0] O_IDLE   = 6'b111_000;
  localparam logic [5:0] O_FREEZE = 6'b000_010;
  localparam logic [5:0] O_LSTALL = 6'b001_100;
  localparam logic [5:0] O_FLUSH  = 6'b111_001;

  // Input vector: {load_use, branch_taken, jump, mem_req, mem_ready}
  localparam logic [4:0] I_NONE = 5'b00000;
  localparam logic [4:0] I_LU   = 5'b10000;
  localparam logic [4:0] I_BR   = 5'b01000;
  localparam logic [4:0] I_JP   = 5'b00100;
  localparam logic [4:0] I_RQ   = 5'b00010;
  localparam logic [4:0] I_RDY  = 5'b00001;

  typedef struct {
    logic [5:0]  outs;
    logic        tout;
    logic [15:0] stall;
    logic [15:0] flush;
    int          id;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        load_use_i, branch_taken_i, jump_i, mem_req_i, mem_ready_i;
  logic        pc_write_o, if_id_write_o, ex_mem_write_o;
  logic        id_ex_bubble_o, mem_wb_bubble_o, if_id_flush_o, mem_timeout_o;
  logic [15:0] stall_cycles_o, flush_count_o;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   vec_id = 0;

  pipeline_stall_sequencer #(.MEM_TIMEOUT(16)) dut (
    .clk             (clk),
    .reset           (reset),
    .load_use_i      (load_use_i),
    .branch_taken_i  (branch_taken_i),
    .jump_i          (jump_i),
    .mem_req_i       (mem_req_i),
    .mem_ready_i     (mem_ready_i),
    .pc_write_o      (pc_write_o),
    .if_id_write_o   (if_id_write_o),
    .ex_mem_write_o  (ex_mem_write_o),
    .id_ex_bubble_o  (id_ex_bubble_o),
    .mem_wb_bubble_o (mem_wb_bubble_o),
    .if_id_flush_o   (if_id_flush_o),
    .mem_timeout_o   (mem_timeout_o),
    .stall_cycles_o  (stall_cycles_o),
    .flush_count_o   (flush_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one vector and queue what the DUT must show during that cycle.
  // Counter expectations are the STALL_PERF_EN values; without it they are 0.
  task automatic step(input logic rst_v, input logic [4:0] in_v, input logic [5:0] exp_o,
                      input logic exp_to, input int exp_s, input int exp_f);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst_v;
    {load_use_i, branch_taken_i, jump_i, mem_req_i, mem_ready_i} = in_v;
    e.outs = exp_o;
    e.tout = exp_to;
`ifdef STALL_PERF_EN
    e.stall = 16'(exp_s);
    e.flush = 16'(exp_f);
`else
    e.stall = 16'(exp_s * 0);
    e.flush = 16'(exp_f * 0);
`endif
    e.id = vec_id;
    vec_id++;
    sb.push_back(e);
  endtask

  // Monitor: compare the presented outputs against the oldest expectation
  initial begin
    exp_t e;
    logic [5:0] act;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        act = {pc_write_o, if_id_write_o, ex_mem_write_o, id_ex_bubble_o, mem_wb_bubble_o, if_id_flush_o};
        checks++;
        if (act !== e.outs) begin
          errors++;
          $display("FAIL ctrl vec%0d: got %b expected %b", e.id, act, e.outs);
        end
        checks++;
        if (mem_timeout_o !== e.tout) begin
          errors++;
          $display("FAIL timeout vec%0d: got %b expected %b", e.id, mem_timeout_o, e.tout);
        end
        checks++;
        if (stall_cycles_o !== e.stall) begin
          errors++;
          $display("FAIL stall_cycles vec%0d: got %0d expected %0d", e.id, stall_cycles_o, e.stall);
        end
        checks++;
        if (flush_count_o !== e.flush) begin
          errors++;
          $display("FAIL flush_count vec%0d: got %0d expected %0d", e.id, flush_count_o, e.flush);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", sb.size());
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  // Driver
  initial begin
    reset = 1'b0;
    {load_use_i, branch_taken_i, jump_i, mem_req_i, mem_ready_i} = I_NONE;

    // Reset state, then release
    step(1'b0, I_NONE, O_IDLE, 1'b0, 0, 0);
    step(1'b0, I_NONE, O_IDLE, 1'b0, 0, 0);
    step(1'b1, I_NONE, O_IDLE, 1'b0, 0, 0);

    // Load-use for two cycles: one stall cycle, then LOAD_STALL ignores it
    step(1'b1, I_LU,   O_LSTALL, 1'b0, 0, 0);
    step(1'b1, I_LU,   O_IDLE,   1'b0, 1, 0);
    step(1'b1, I_NONE, O_IDLE,   1'b0, 1, 0);

    // Branch with load-use: no flush; branch alone next cycle: flush
    step(1'b1, I_LU | I_BR, O_LSTALL, 1'b0, 1, 0);
    step(1'b1, I_BR,        O_FLUSH,  1'b0, 2, 0);
    step(1'b1, I_NONE,      O_IDLE,   1'b0, 2, 1);

    // Jump in RUN flushes; stray mem_ready in RUN is ignored
    step(1'b1, I_JP,   O_FLUSH, 1'b0, 2, 1);
    step(1'b1, I_NONE, O_IDLE,  1'b0, 2, 2);
    step(1'b1, I_RDY,  O_IDLE,  1'b0, 2, 2);

    // Reset clears counters
    step(1'b0, I_NONE, O_IDLE, 1'b0, 0, 0);
    step(1'b1, I_NONE, O_IDLE, 1'b0, 0, 0);

    // Three frozen cycles, released on the ready cycle
    step(1'b1, I_RQ,         O_FREEZE, 1'b0, 0, 0);
    step(1'b1, I_RQ,         O_FREEZE, 1'b0, 1, 0);
    step(1'b1, I_RQ,         O_FREEZE, 1'b0, 2, 0);
    step(1'b1, I_RQ | I_RDY, O_IDLE,   1'b0, 3, 0);
    step(1'b1, I_NONE,       O_IDLE,   1'b0, 3, 0);

    // Memory wait beats load-use; ready cycle applies RUN rules (load-use -> stall)
    step(1'b1, I_LU | I_RQ,                O_FREEZE, 1'b0, 3, 0);
    step(1'b1, I_LU | I_BR | I_RQ | I_RDY, O_LSTALL, 1'b0, 4, 0);
    // Memory wait checked from LOAD_STALL; ready cycle with branch flushes
    step(1'b1, I_RQ,                O_FREEZE, 1'b0, 5, 0);
    step(1'b1, I_BR | I_RQ | I_RDY, O_FLUSH,  1'b0, 6, 0);
    step(1'b1, I_NONE,              O_IDLE,   1'b0, 6, 1);
    // Inside MEM_WAIT, load-use and branch do nothing while not ready
    step(1'b1, I_RQ,                O_FREEZE, 1'b0, 6, 1);
    step(1'b1, I_LU | I_BR | I_RQ,  O_FREEZE, 1'b0, 7, 1);
    step(1'b1, I_RDY,               O_IDLE,   1'b0, 8, 1);
    step(1'b1, I_NONE,              O_IDLE,   1'b0, 8, 1);

    // Reset during the second MEM_WAIT cycle aborts the wait
    step(1'b1, I_RQ,   O_FREEZE, 1'b0, 8, 1);
    step(1'b1, I_RQ,   O_FREEZE, 1'b0, 9, 1);
    step(1'b0, I_NONE, O_IDLE,   1'b0, 0, 0);
    step(1'b1, I_NONE, O_IDLE,   1'b0, 0, 0);

    // Timeout: entry cycle plus 16 MEM_WAIT cycles frozen, then flag and release
    step(1'b1, I_RQ, O_FREEZE, 1'b0, 0, 0);
    for (int k = 0; k < 16; k++) begin
      step(1'b1, I_RQ, O_FREEZE, 1'b0, k + 1, 0);
    end
    step(1'b1, I_NONE,       O_IDLE, 1'b1, 17, 0);
    step(1'b1, I_RQ | I_RDY, O_IDLE, 1'b1, 17, 0);
    step(1'b1, I_NONE,       O_IDLE, 1'b1, 17, 0);
    // Only reset clears the flag
    step(1'b0, I_NONE, O_IDLE, 1'b0, 0, 0);
    step(1'b1, I_NONE, O_IDLE, 1'b0, 0, 0);

    // Let the monitor drain the last expectation
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_sequencer.md
PIPELINE_STALL_SEQUENCER -- requirements
Module: pipeline_stall_sequencer

Interface
REQ-001 The block SHALL have parameter MEM_TIMEOUT, default 16, giving the maximum data-memory wait cycles before the timeout is flagged (legal range 2..31).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port load_use_i, input, 1 bit: load-use hazard detected (ID/EX load, dependent instruction in IF/ID).
REQ-005 The block SHALL have port branch_taken_i, input, 1 bit: a taken beq/bne resolved in ID.
REQ-006 The block SHALL have port jump_i, input, 1 bit: j, jal or jr in ID.
REQ-007 The block SHALL have port mem_req_i, input, 1 bit: the EX/MEM instruction accesses data memory.
REQ-008 The block SHALL have port mem_ready_i, input, 1 bit: data memory completes the access this cycle.
REQ-009 The block SHALL have outputs pc_write_o, if_id_write_o and ex_mem_write_o, each 1 bit: register enables for PC, IF/ID and EX/MEM.
REQ-010 The block SHALL have output id_ex_bubble_o, 1 bit: zero the ID/EX control fields.
REQ-011 The block SHALL have output mem_wb_bubble_o, 1 bit: zero the MEM/WB control fields.
REQ-012 The block SHALL have output if_id_flush_o, 1 bit: replace the IF/ID instruction with NOP.
REQ-013 The block SHALL have output mem_timeout_o, 1 bit: sticky memory-timeout error flag.
REQ-014 The block SHALL have outputs stall_cycles_o and flush_count_o, each 16 bits: performance counters.

Function
REQ-015 The FSM SHALL have the states RUN, LOAD_STALL and MEM_WAIT. Outputs are combinational from state and inputs; state is registered.
REQ-016 Idle outputs SHALL be: all enables 1, all bubbles 0, flush 0.
REQ-017 In RUN, when mem_req_i=1 and mem_ready_i=0 (the memory-wait condition), the block SHALL drive pc_write_o, if_id_write_o and ex_mem_write_o to 0 and mem_wb_bubble_o to 1 in that same cycle, and go to MEM_WAIT. Memory wait has the highest priority.
REQ-018 In RUN without a memory wait, when load_use_i=1, the block SHALL drive pc_write_o and if_id_write_o to 0 and id_ex_bubble_o to 1, and go to LOAD_STALL.
REQ-019 When load_use_i=1 coincides with branch_taken_i or jump_i, if_id_flush_o SHALL stay 0, because the branch re-resolves after the stall.
REQ-020 In RUN with no memory wait and no load-use, if_id_flush_o SHALL equal branch_taken_i OR jump_i, and the state SHALL remain RUN.
REQ-021 In LOAD_STALL, load_use_i SHALL be ignored: idle outputs apply, flush follows REQ-020, and the memory-wait check of REQ-017 applies. The next state is RUN, or MEM_WAIT if a memory wait occurs.
REQ-022 In MEM_WAIT with mem_ready_i=0, the freeze outputs of REQ-017 SHALL hold and id_ex_bubble_o and if_id_flush_o SHALL be 0.
REQ-023 In MEM_WAIT, a 5-bit wait counter SHALL increment each cycle; it is cleared on entering MEM_WAIT.
REQ-024 In MEM_WAIT with mem_ready_i=1, the freeze SHALL release that same cycle and the RUN rules of REQ-018 to REQ-020 SHALL apply; the next state is RUN or LOAD_STALL.
REQ-025 When the wait counter reaches MEM_TIMEOUT-1 with mem_ready_i=0, the block SHALL set mem_timeout_o (held until reset), release the freeze the next cycle and return to RUN.
REQ-026 A mem_ready_i=1 while not in MEM_WAIT SHALL be ignored.

Reset
REQ-027 While reset=0, the block SHALL force state RUN, the wait counter to 0, mem_timeout_o to 0 and both performance counters to 0, asynchronously.
REQ-028 Outputs during reset SHALL follow the RUN rules; with all inputs 0 they are the idle values.
REQ-029 Reset asserted mid-MEM_WAIT SHALL abort the wait immediately, with no timeout recorded.

Configuration
REQ-030 With STALL_PERF_EN defined, stall_cycles_o SHALL increment on every cycle with pc_write_o=0, and flush_count_o SHALL increment on every cycle with if_id_flush_o=1.
REQ-031 With STALL_PERF_EN defined, both counters SHALL saturate at 16'hFFFF.
REQ-032 Without STALL_PERF_EN, both counter ports SHALL remain present and tied to 16'h0000, and no counter registers are inferred.

Verification
REQ-033 load_use_i=1 for 2 cycles from RUN -> exactly 1 cycle of pc_write_o=0 and id_ex_bubble_o=1, then pc_write_o=1 while load_use_i is still 1 (LOAD_STALL).
REQ-034 branch_taken_i=1 with load_use_i=1, then branch_taken_i=1 alone -> flush 0 in cycle 1 and flush 1 in cycle 2; flush_count_o=1 with STALL_PERF_EN.
REQ-035 mem_req_i=1, mem_ready_i=0 for 3 cycles then 1 -> 3 frozen cycles, release on the ready cycle; stall_cycles_o=3.
REQ-036 mem_req_i=1, mem_ready_i=0 held with MEM_TIMEOUT=16 -> mem_timeout_o=1 after the 16th wait cycle, pipeline released, flag sticky until reset.
REQ-037 reset=0 asserted in the 2nd MEM_WAIT cycle -> idle outputs immediately, mem_timeout_o=0, counters 0.
REQ-038 Without STALL_PERF_EN, rerun the REQ-035 scenario -> stall_cycles_o=0 throughout.
